// File: rtl/fpadd_pkg.sv
// Shared definitions for the FP-add operand loader: default sizing and FSM encoding.
package fpadd_pkg;

    localparam int NUM_DEFAULT     = 10;
    localparam int ADDR_W_DEFAULT  = 4;
    localparam int BYTES_PER_ENTRY = 8;
    localparam int BYTE_IDX_W      = $clog2(BYTES_PER_ENTRY);
    localparam int ENTRY_W         = 8 * BYTES_PER_ENTRY;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/fpadd_operand_loader.sv
// Assembles a byte stream into 64-bit {A,B} operand pairs and writes NUM of them
// into the operand RAM through a registered write port.
module fpadd_operand_loader
    import fpadd_pkg::*;
#(
    parameter int NUM    = NUM_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [ENTRY_W-1:0]    wr_data,
    output logic                  load_done,
    output logic [ADDR_W-1:0]     entry_count,
    output state_t                state
);

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
    // byte_ready depends only on the state register, never on byte_valid.

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE  = BYTE_IDX_W'(BYTES_PER_ENTRY - 1);
    localparam logic [ADDR_W-1:0]     LAST_ENTRY = ADDR_W'(NUM - 1);

    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [ENTRY_W-1:0]    shift_q;
    logic [ENTRY_W-1:0]    next_shift;
    logic                  accept;

    assign byte_ready = (state == ST_IDLE) || (state == ST_COLLECT);
    assign accept     = byte_valid && byte_ready;
    // MSB-first: the first byte of an entry ends up in bits [63:56].
    assign next_shift = {shift_q[ENTRY_W-9:0], byte_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            byte_idx    <= '0;
            shift_q     <= '0;
            entry_count <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            load_done   <= 1'b0;
        end else if (start) begin
            // wr_addr/wr_data keep their last values; only the strobe drops.
            state       <= ST_IDLE;
            byte_idx    <= '0;
            shift_q     <= '0;
            entry_count <= '0;
            wr_en       <= 1'b0;
            load_done   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (accept) begin
                        shift_q  <= next_shift;
                        byte_idx <= byte_idx + 1'b1;
                        state    <= ST_COLLECT;
                        if (byte_idx == LAST_BYTE) begin
                            state   <= ST_WRITE;
                            wr_en   <= 1'b1;
                            wr_addr <= entry_count;
                            wr_data <= next_shift;
                        end
                    end
                end
                ST_WRITE: begin
                    entry_count <= entry_count + 1'b1;
                    if (entry_count == LAST_ENTRY) begin
                        state     <= ST_DONE;
                        load_done <= 1'b1;
                    end else begin
                        state <= ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fpadd_operand_loader.md
FPADD_OPERAND_LOADER -- requirements
Module: fpadd_operand_loader

Interface
REQ-001 The block SHALL have parameter NUM, default 10, meaning the number of FP-add operand pairs (entries) loaded per run.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning the operand-memory address width, with 2**ADDR_W >= NUM.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle pulse that clears the loader and re-arms it.
REQ-006 The block SHALL have port byte_valid, input, 1 bit: byte_data is valid this cycle.
REQ-007 The block SHALL have port byte_data, input, 8 bits: incoming operand byte stream.
REQ-008 The block SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The block SHALL have port wr_en, output, 1 bit: operand-memory write strobe.
REQ-010 The block SHALL have port wr_addr, output, ADDR_W bits: operand-memory entry index.
REQ-011 The block SHALL have port wr_data, output, 64 bits: operand A in [63:32], operand B in [31:0].
REQ-012 The block SHALL have port load_done, output, 1 bit: all NUM entries have been written.
REQ-013 The block SHALL have port entry_count, output, ADDR_W bits: the number of entries written so far.

Function
REQ-014 A byte SHALL be accepted only in a cycle where byte_valid and byte_ready are both 1.
REQ-015 Bytes SHALL be assembled MSB-first: bytes 0-3 form A[31:24..7:0] and bytes 4-7 form B[31:24..7:0].
REQ-016 The FSM SHALL have states IDLE, COLLECT, WRITE and DONE.
REQ-017 Transitions SHALL be: IDLE->COLLECT on the first accepted byte; COLLECT->WRITE on the 8th accepted byte; WRITE->COLLECT if entry_count+1 < NUM; WRITE->DONE if entry_count+1 == NUM.
REQ-018 byte_ready SHALL be 1 in IDLE and COLLECT, and 0 in WRITE and DONE.
REQ-019 In WRITE (exactly one cycle, the cycle after the 8th byte is accepted), the outputs SHALL be wr_en=1, wr_addr=entry_count and wr_data=the assembled 64 bits; entry_count SHALL increment at the end of that cycle.
REQ-020 wr_en SHALL be 0 in every state other than WRITE.
REQ-021 wr_data and wr_addr SHALL hold their values when wr_en=0.
REQ-022 load_done SHALL be 1 in DONE and 0 in every other state.
REQ-023 In DONE, incoming bytes SHALL be ignored and no further writes SHALL occur.
REQ-024 start in any state SHALL, on the next cycle, give state IDLE, byte index 0, entry_count 0, wr_en 0 and load_done 0, discarding any partial entry.
REQ-025 start and an accepted byte in the same cycle: start SHALL win and the byte SHALL be dropped.
REQ-026 Byte gaps (byte_valid=0) SHALL stall assembly without a time limit and without losing data.
REQ-027 Latency SHALL be 1 cycle from acceptance of the 8th byte to wr_en; sustained throughput SHALL be 1 entry per 9 cycles.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL enter IDLE with byte_ready=1, wr_en=0, wr_addr=0, wr_data=0, load_done=0, entry_count=0 and byte index 0.
REQ-029 rst asserted mid-entry or mid-WRITE SHALL abort the entry with no write issued in the following cycle.
REQ-030 rst SHALL take priority over start.

Structure
REQ-031 The shared package fpadd_pkg SHALL hold: the NUM and ADDR_W defaults, BYTES_PER_ENTRY=8, and the FSM state encoding.
REQ-032 The loader SHALL be a single module with no sub-module; the byte shift register and counters SHALL be inline.
REQ-033 The outputs wr_en, wr_addr and wr_data SHALL be registered to drive the operand RAM write port directly.

Verification
REQ-034 The bench SHALL cover: bytes 3F 80 00 00 40 00 00 00 back-to-back after reset -> one cycle after the last byte, wr_en=1, wr_addr=0, wr_data=3F800000_40000000, and byte_ready=0 for that cycle only.
REQ-035 The bench SHALL cover: 10 entries streamed with random byte_valid gaps -> exactly 10 writes at addresses 0..9 with correct data, then load_done=1, and entry_count=10 (4'hA).
REQ-036 The bench SHALL cover: an 11th entry's bytes presented in DONE -> byte_ready=0, no wr_en, and load_done stays 1.
REQ-037 The bench SHALL cover: start pulsed after 5 bytes of entry 3 -> no write of the partial entry, and the next full entry is written at wr_addr=0 with entry_count restarting at 0.
REQ-038 The bench SHALL cover: rst held for one cycle during WRITE -> wr_en=0 next cycle, all outputs at reset values, and a clean reload starting at address 0.
REQ-039 The bench SHALL cover: start coincident with an accepted byte 0xAB -> the byte is dropped, and the next entry assembles from the following byte.
